ntt_mdc_commutator: RTL and testbench



---
 rtl/ntt_mdc_commutator.sv | 141 ++++++++++++++
 tb/tb_ntt_mdc_commutator.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ntt_mdc_commutator.sv
// ntt_mdc_commutator: radix-2 MDC delay-switch-delay reorder unit with valid-gated advance and flush drain
module ntt_mdc_commutator #(
  parameter int LOGQ = 32,
  parameter int DEPTH = 4,
  parameter int LANES = 1,
  parameter int USE_RAM = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [2*LANES*LOGQ-1:0] in_data,
  input  logic                    flush,
  output logic                    out_valid,
  output logic [2*LANES*LOGQ-1:0] out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    err
);
  localparam int W = LANES * LOGQ;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, ocnt_q, ocnt_d;
  logic [PW-1:0] pcnt_q, pcnt_d, pcnt_adv, fcnt_q, fcnt_d;
  logic [2*W-1:0] out_data_q, out_data_d, src;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d, busy_q, busy_d, err_q, err_d;
  logic beat, primed, clr;
  logic [W-1:0] x0, x1, y0, y1, w;
  logic [1:0][W-1:0] din, dout;

  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_last = out_last_q;
  assign busy = busy_q;
  assign err = err_q;

  // Control and output registers; counters only move on beats
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ocnt_q <= '0;
      pcnt_q <= '0;
      fcnt_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      busy_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ocnt_q <= ocnt_d;
      pcnt_q <= pcnt_d;
      fcnt_q <= fcnt_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      busy_q <= busy_d;
      err_q <= err_d;
    end
  end

  // Next state: a flush that lands before priming completes just discards and returns to IDLE
  always_comb begin
    beat = in_valid || state_q == FLUSH;
    primed = pcnt_q == PW'(DEPTH);
    pcnt_adv = (beat && !primed) ? pcnt_q + 1'b1 : pcnt_q;
    state_d = state_q == FLUSH ? (fcnt_q == PW'(DEPTH - 1) ? IDLE : FLUSH)
            : flush ? (pcnt_adv == PW'(DEPTH) ? FLUSH : IDLE)
            : in_valid ? RUN : state_q;
    clr = state_d == IDLE;
    cnt_d = clr ? '0 : cnt_q + CW'(beat);
    ocnt_d = clr ? '0 : ocnt_q + CW'(beat && primed);
    pcnt_d = clr ? '0 : pcnt_adv;
    fcnt_d = state_q == FLUSH ? fcnt_q + 1'b1 : '0;
  end

  // Outputs and datapath: zero-filled flush beats, switch between the two delays
  always_comb begin
    src = state_q == FLUSH ? '0 : in_data;
    x0 = '0;
    x1 = '0;
    for (int p = 0; p < LANES; p++) begin
      x0[p*LOGQ +: LOGQ] = src[2*p*LOGQ +: LOGQ];
      x1[p*LOGQ +: LOGQ] = src[(2*p+1)*LOGQ +: LOGQ];
    end
    y1 = cnt_q[CW-1] ? x0 : dout[0];
    w = cnt_q[CW-1] ? dout[0] : x0;
    y0 = dout[1];
    din = {w, x1};
    out_valid_d = beat && primed;
    out_last_d = out_valid_d && &ocnt_q;
    out_data_d = out_data_q;
    if (out_valid_d)
      for (int p = 0; p < LANES; p++) begin
        out_data_d[2*p*LOGQ +: LOGQ] = y0[p*LOGQ +: LOGQ];
        out_data_d[(2*p+1)*LOGQ +: LOGQ] = y1[p*LOGQ +: LOGQ];
      end
    busy_d = (state_q == RUN && primed) || state_q == FLUSH;
    err_d = err_q || (in_valid && state_q == FLUSH);
  end

  if (USE_RAM != 0) begin : g_ram
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [1:0][W-1:0] rd_q, rd_d;
    logic [W-1:0] mem [2][2**AW];
    // Read address runs one cycle ahead so the registered read is ready on the next beat
    always_comb begin
      ptr_d = rst ? '0 : beat ? (ptr_q == AW'(DEPTH - 1) ? '0 : ptr_q + 1'b1) : ptr_q;
      for (int i = 0; i < 2; i++)
        rd_d[i] = (beat && ptr_d == ptr_q) ? din[i] : mem[i][ptr_d];
    end
    // Circular buffers: write at the current slot, prefetch the next one
    always_ff @(posedge clk) begin
      ptr_q <= ptr_d;
      rd_q <= rd_d;
      if (beat)
        for (int i = 0; i < 2; i++)
          mem[i][ptr_q] <= din[i];
    end
    assign dout = rd_q;
  end else begin : g_sr
    logic [1:0][DEPTH-1:0][W-1:0] sr_q, sr_d;
    // Valid-enabled shift registers, one per delay
    always_comb begin
      sr_d = sr_q;
      if (beat)
        for (int i = 0; i < 2; i++) begin
          for (int k = DEPTH - 1; k > 0; k--)
            sr_d[i][k] = sr_q[i][k-1];
          sr_d[i][0] = din[i];
        end
    end
    // Delay storage needs no reset; priming hides stale contents
    always_ff @(posedge clk) sr_q <= sr_d;
    assign dout = {sr_q[1][DEPTH-1], sr_q[0][DEPTH-1]};
  end
endmodule

// File: tb/tb_ntt_mdc_commutator.sv
// tb_ntt_mdc_commutator: scoreboard bench for the MDC commutator over shift-register and RAM variants
module tb_ntt_mdc_commutator;
  typedef struct packed {
    logic [191:0] d;
    logic         l;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iv_a = 1'b0, fl_a = 1'b0, iv_b = 1'b0, fl_b = 1'b0;
  logic [63:0] din_a = '0;
  logic [191:0] din_b = '0;
  logic ov[4], ol[4], bz[4], er[4];
  logic [63:0] oda[2];
  logic [191:0] odb[2];
  logic [191:0] od[4];
  int s0[3][64], s1[3][64];
  int n_chk = 0, n_fail = 0;
  bit started = 1'b0, log_en = 1'b0;
  logic [63:0] log_q[$];
  exp_t exp_q[4][$];
  exp_t ce;
  int pin0[8] = '{0, 1, 2, 3, 100, 101, 102, 103};
  int pin1[8] = '{4, 5, 6, 7, 104, 105, 106, 107};

  always #5 clk = ~clk;

  ntt_mdc_commutator #(.LOGQ(32), .DEPTH(4), .LANES(1), .USE_RAM(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv_a), .in_data(din_a), .flush(fl_a),
    .out_valid(ov[0]), .out_data(oda[0]), .out_last(ol[0]), .busy(bz[0]), .err(er[0]));
  ntt_mdc_commutator #(.LOGQ(32), .DEPTH(4), .LANES(1), .USE_RAM(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv_a), .in_data(din_a), .flush(fl_a),
    .out_valid(ov[1]), .out_data(oda[1]), .out_last(ol[1]), .busy(bz[1]), .err(er[1]));
  ntt_mdc_commutator #(.LOGQ(32), .DEPTH(1), .LANES(3), .USE_RAM(0)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv_b), .in_data(din_b), .flush(fl_b),
    .out_valid(ov[2]), .out_data(odb[0]), .out_last(ol[2]), .busy(bz[2]), .err(er[2]));
  ntt_mdc_commutator #(.LOGQ(32), .DEPTH(1), .LANES(3), .USE_RAM(1)) u3 (
    .clk(clk), .rst(rst), .in_valid(iv_b), .in_data(din_b), .flush(fl_b),
    .out_valid(ov[3]), .out_data(odb[1]), .out_last(ol[3]), .busy(bz[3]), .err(er[3]));

  assign od[0] = 192'(oda[0]);
  assign od[1] = 192'(oda[1]);
  assign od[2] = odb[0];
  assign od[3] = odb[1];

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Group 0 = D4/L1 pair (u0,u1), group 1 = D1/L3 pair (u2,u3); expected outputs come from the mapping rules
  task automatic stream(input int g, input int n, input int b0, input int b1,
                        input bit toggle, input bit do_flush, input bit junk);
    int d, lanes, nout, fr, y0, y1;
    exp_t e;
    d = g ? 1 : 4;
    lanes = g ? 3 : 1;
    for (int p = 0; p < 3; p++)
      for (int t = 0; t < 64; t++) begin
        s0[p][t] = 0;
        s1[p][t] = 0;
      end
    for (int p = 0; p < lanes; p++)
      for (int t = 0; t < n; t++) begin
        s0[p][t] = (p + 1) * (b0 + t);
        s1[p][t] = (p + 1) * (b1 + t);
      end
    nout = do_flush ? (n >= d ? n : 0) : (n > d ? n - d : 0);
    for (int j = 0; j < nout; j++) begin
      fr = j % (2 * d);
      e.d = '0;
      for (int p = 0; p < lanes; p++) begin
        y0 = fr < d ? s0[p][j] : s1[p][j-d];
        y1 = fr < d ? s0[p][j+d] : s1[p][j];
        e.d[2*p*32 +: 32] = y0;
        e.d[(2*p+1)*32 +: 32] = y1;
      end
      e.l = fr == 2 * d - 1;
      exp_q[2*g].push_back(e);
      exp_q[2*g+1].push_back(e);
    end
    for (int t = 0; t < n; t++) begin
      if (g == 0) begin
        iv_a = 1'b1;
        din_a = {s1[0][t], s0[0][t]};
      end else begin
        iv_b = 1'b1;
        for (int p = 0; p < 3; p++) begin
          din_b[2*p*32 +: 32] = s0[p][t];
          din_b[(2*p+1)*32 +: 32] = s1[p][t];
        end
      end
      cyc();
      iv_a = 1'b0;
      iv_b = 1'b0;
      if (toggle) cyc();
    end
    if (do_flush) begin
      if (g == 0) fl_a = 1'b1; else fl_b = 1'b1;
      cyc();
      fl_a = 1'b0;
      fl_b = 1'b0;
      if (junk) begin
        cyc();
        iv_a = 1'b1;
        din_a = 64'hdead_beef_1234_5678;
        cyc();
        iv_a = 1'b0;
      end
    end
  endtask

  // Scoreboard compare on the falling edge, away from output updates
  always @(negedge clk) begin
    if (started)
      for (int k = 0; k < 4; k++) begin
        if (ov[k]) begin
          if (exp_q[k].size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_out_valid[%0d]: got data %0h with nothing expected at %0t", k, od[k], $time);
          end else begin
            ce = exp_q[k].pop_front();
            chk($sformatf("out_data[%0d]", k), od[k], ce.d);
            chk($sformatf("out_last[%0d]", k), 192'(ol[k]), 192'(ce.l));
            if (k == 0 && log_en) log_q.push_back(od[0][63:0]);
          end
        end else
          chk($sformatf("last_when_idle[%0d]", k), 192'(ol[k]), 192'(0));
      end
  end

  initial begin
    logic [63:0] pv;
    repeat (3) cyc();
    rst = 1'b0;
    started = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_valid[%0d]", k), 192'(ov[k]), 0);
      chk($sformatf("rst_last[%0d]", k), 192'(ol[k]), 0);
      chk($sformatf("rst_data[%0d]", k), od[k], 0);
      chk($sformatf("rst_busy[%0d]", k), 192'(bz[k]), 0);
      chk($sformatf("rst_err[%0d]", k), 192'(er[k]), 0);
    end
    log_en = 1'b1;
    stream(0, 8, 0, 100, 1'b0, 1'b1, 1'b0);
    repeat (4) cyc();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("flush_last_valid[%0d]", k), 192'(ov[k]), 1);
      chk($sformatf("flush_last_mark[%0d]", k), 192'(ol[k]), 1);
      chk($sformatf("flush_busy_high[%0d]", k), 192'(bz[k]), 1);
    end
    cyc();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("flush_busy_low[%0d]", k), 192'(bz[k]), 0);
      chk($sformatf("flush_valid_low[%0d]", k), 192'(ov[k]), 0);
    end
    log_en = 1'b0;
    repeat (3) cyc();
    chk("pin_count", 192'(log_q.size()), 8);
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      pv = {pin1[i][31:0], pin0[i][31:0]};
      chk($sformatf("pin_out[%0d]", i), 192'(log_q[i]), 192'(pv));
    end
    stream(0, 8, 0, 100, 1'b1, 1'b1, 1'b0);
    repeat (8) cyc();
    stream(0, 2, 50, 150, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("early_flush_busy[%0d]", k), 192'(bz[k]), 0);
      chk($sformatf("early_flush_valid[%0d]", k), 192'(ov[k]), 0);
    end
    repeat (2) cyc();
    stream(0, 8, 200, 300, 1'b0, 1'b1, 1'b0);
    repeat (8) cyc();
    stream(0, 8, 400, 500, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) chk($sformatf("err_set[%0d]", k), 192'(er[k]), 1);
    repeat (6) cyc();
    for (int k = 0; k < 2; k++) chk($sformatf("err_sticky[%0d]", k), 192'(er[k]), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) chk($sformatf("err_cleared[%0d]", k), 192'(er[k]), 0);
    stream(0, 5, 700, 800, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("midrst_valid[%0d]", k), 192'(ov[k]), 0);
      chk($sformatf("midrst_busy[%0d]", k), 192'(bz[k]), 0);
    end
    stream(0, 8, 600, 900, 1'b0, 1'b1, 1'b0);
    repeat (8) cyc();
    stream(1, 16, 10, 20, 1'b0, 1'b1, 1'b0);
    repeat (6) cyc();
    stream(1, 16, 30, 40, 1'b1, 1'b1, 1'b0);
    repeat (6) cyc();
    for (int k = 0; k < 4; k++) chk($sformatf("drained[%0d]", k), 192'(exp_q[k].size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
